// File: rtl/vmicro16_soc.sv
// rtl/vmicro16_soc.sv - multi-core summation SoC with reduction, GPIO publish and sticky halt
module vmicro16_soc #(
  parameter int N_CORES    = 4,
  parameter int SUM_LAST   = 239,
  parameter int DATA_WIDTH = 16,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  halt,
  output logic [GPIO_WIDTH-1:0] gpio1
);
  // One spare bit so v_k can step past SUM_LAST without wrapping.
  localparam int CW = $clog2(SUM_LAST + N_CORES) + 1;

  typedef enum logic [1:0] {S_RUN, S_REDUCE, S_DONE} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_v   [N_CORES];
  logic [DATA_WIDTH-1:0]   r_acc [N_CORES];
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_halt;
  logic [GPIO_WIDTH-1:0]   r_gpio1;
  logic [N_CORES-1:0]      w_done;
  logic [DATA_WIDTH-1:0]   w_sum;

  always_comb begin
    w_sum  = '0;
    w_done = '0;
    for (int k = 0; k < N_CORES; k++) begin
      w_done[k] = (r_v[k] > CW'(SUM_LAST));
      w_sum     = w_sum + r_acc[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_result <= '0;
      r_halt   <= 1'b0;
      r_gpio1  <= '0;
      for (int k = 0; k < N_CORES; k++) begin
        r_v[k]   <= CW'(k + 1);
        r_acc[k] <= '0;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          for (int k = 0; k < N_CORES; k++) begin
            if (!w_done[k]) begin
              r_acc[k] <= r_acc[k] + DATA_WIDTH'(r_v[k]);
              r_v[k]   <= r_v[k] + CW'(N_CORES);
            end
          end
          // Completion is judged on values at the start of the cycle.
          if (&w_done) r_state <= S_REDUCE;
        end
        S_REDUCE: begin
          r_result <= w_sum;
          r_gpio1  <= w_sum[GPIO_WIDTH-1:0];
          r_halt   <= 1'b1;
          r_state  <= S_DONE;
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  assign halt  = r_halt;
  assign gpio1 = r_gpio1;
endmodule

// File: tb/tb_vmicro16_soc.sv
// tb/tb_vmicro16_soc.sv - directed checks of vmicro16_soc over several parameter sets
module tb_vmicro16_soc;
  localparam int ND = 5;

  logic       clk;
  logic       reset;
  logic [ND-1:0] w_halt;
  logic [7:0] w_gpio [ND];
  logic [15:0] w_res [ND];

  int checks = 0;
  int errors = 0;

  int rise_edge [ND];
  int rises     [ND];
  int glitch    [ND];

  // Expected values per instance: d0 defaults, d1 N=1, d2 N=3, d3 SUM_LAST=400, d4 SUM_LAST=2
  int          exp_edge [ND] = '{62, 241, 82, 102, 3};
  logic [7:0]  exp_gpio [ND] = '{8'h08, 8'h08, 8'h08, 8'h48, 8'h03};
  logic [15:0] exp_res  [ND] = '{16'h7008, 16'h7008, 16'h7008, 16'h3948, 16'h0003};

  vmicro16_soc #(.N_CORES(4), .SUM_LAST(239)) u_d0 (.clk(clk), .reset(reset), .halt(w_halt[0]), .gpio1(w_gpio[0]));
  vmicro16_soc #(.N_CORES(1), .SUM_LAST(239)) u_d1 (.clk(clk), .reset(reset), .halt(w_halt[1]), .gpio1(w_gpio[1]));
  vmicro16_soc #(.N_CORES(3), .SUM_LAST(239)) u_d2 (.clk(clk), .reset(reset), .halt(w_halt[2]), .gpio1(w_gpio[2]));
  vmicro16_soc #(.N_CORES(4), .SUM_LAST(400)) u_d3 (.clk(clk), .reset(reset), .halt(w_halt[3]), .gpio1(w_gpio[3]));
  vmicro16_soc #(.N_CORES(4), .SUM_LAST(2))   u_d4 (.clk(clk), .reset(reset), .halt(w_halt[4]), .gpio1(w_gpio[4]));

  assign w_res[0] = u_d0.r_result;
  assign w_res[1] = u_d1.r_result;
  assign w_res[2] = u_d2.r_result;
  assign w_res[3] = u_d3.r_result;
  assign w_res[4] = u_d4.r_result;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input int n_edges);
    logic [ND-1:0] prev;
    prev = '0;
    for (int i = 0; i < ND; i++) begin
      rise_edge[i] = 0;
      rises[i]     = 0;
      glitch[i]    = 0;
    end
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < ND; i++) begin
        if (w_halt[i] && !prev[i]) begin
          rises[i]++;
          if (rise_edge[i] == 0) rise_edge[i] = e;
        end
        if (!w_halt[i] && w_gpio[i] != 8'h00) glitch[i] = 1;
      end
      prev = w_halt;
    end
  endtask

  task automatic check_seq(input string pass);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s_d%0d_halt_edge", pass, i), rise_edge[i], exp_edge[i]);
      chk($sformatf("%s_d%0d_rises", pass, i), rises[i], 1);
      chk($sformatf("%s_d%0d_gpio_early", pass, i), glitch[i], 0);
      chk($sformatf("%s_d%0d_halt_final", pass, i), {31'd0, w_halt[i]}, 1);
      chk($sformatf("%s_d%0d_gpio", pass, i), {24'd0, w_gpio[i]}, {24'd0, exp_gpio[i]});
      chk($sformatf("%s_d%0d_result", pass, i), {16'd0, w_res[i]}, {16'd0, exp_res[i]});
    end
  endtask

  task automatic check_cleared(input string pass);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s_d%0d_halt", pass, i), {31'd0, w_halt[i]}, 0);
      chk($sformatf("%s_d%0d_gpio", pass, i), {24'd0, w_gpio[i]}, 0);
      chk($sformatf("%s_d%0d_result", pass, i), {16'd0, w_res[i]}, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_cleared("in_reset");
    reset = 1'b0;
    run_seq(260);
    check_seq("first");

    // Asynchronous reset from DONE, applied between clock edges
    #2;
    reset = 1'b1;
    #1;
    check_cleared("reset_done");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset again 20 cycles into RUN; d4 has already published by then
    repeat (20) @(posedge clk);
    #2;
    chk("mid_d4_halt_before", {31'd0, w_halt[4]}, 1);
    reset = 1'b1;
    #1;
    check_cleared("reset_mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_seq(260);
    check_seq("second");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
